ram512x32_byte_packer: RTL
==========================

Name: ram512x32_byte_packer

Overview:
- Write-side feeder for the 512x32-write / 1024x16-read concatenated RAM block.
- Accepts a byte stream over a valid/ready handshake and packs bytes little-endian into 32-bit words.
- Drives the RAM write port: WA, WD, WEN, WClk_En.
- Tracks frame length and flags completion and full-buffer conditions to the downstream 16-bit reader.

Parameters:
- ADDR_W, 9, RAM write address width.
- DEPTH, 512, number of 32-bit words in the RAM.
- LANES, 4, byte lanes per word. Fixed at 4; other values are unsupported.

Ports:
- Clk  input  1  single clock; also drives the RAM WClk.
- Rst_n  input  1  asynchronous, active-low reset.
- Start  input  1  begin a new frame; clears the write pointer.
- In_Data  input  8  byte payload.
- In_Valid  input  1  byte present.
- In_Last  input  1  qualifies the final byte of a frame.
- In_Ready  output  1  packer can accept a byte this cycle.
- WA  output  ADDR_W  RAM write address.
- WD  output  32  RAM write data.
- WEN  output  4  RAM byte write enables, active high.
- WClk_En  output  1  RAM write strobe, one cycle per word.
- Word_Cnt  output  ADDR_W+1  words written in the current frame, 0..512.
- Full  output  1  DEPTH words written.
- Done  output  1  one-cycle pulse when the frame closes.

Behaviour:
- Reset (async assert, sync release): all outputs 0, state IDLE, lane index 0, shadow word 0.
- States: IDLE, FILL, DONE.
  - IDLE: on Start go to FILL.
  - FILL: on an accepted In_Last, or on the 512th word write, go to DONE.
  - DONE: on Start go to FILL.
- Start in IDLE or DONE does all of: Word_Cnt=0, pointer=0, lane=0, Full=0.
- Start in FILL aborts the frame:
  - the partial shadow word is discarded, with no write issued;
  - pointer and lane are cleared;
  - state stays FILL;
  - no Done pulse.
- Start has priority over a byte accepted in the same cycle; that byte is dropped.
- In_Ready = (state==FILL) && !Full && !Start.
- A byte is accepted when In_Valid && In_Ready.
- Accepted byte goes to shadow lane `lane`, bits [8*lane+7 : 8*lane]; lane then increments.
- Word-complete event: lane==3 on accept, or In_Last on accept.
  - Next cycle: WClk_En=1, WA=pointer, WD=shadow (unfilled lanes 0), WEN = mask of filled lanes, e.g. 2 bytes -> 4'b0011.
  - Lane resets to 0.
  - The pointer and Word_Cnt increment in that write cycle; new values are visible the cycle after.
- Latency: the completing byte is accepted at cycle N; WClk_En is high at cycle N+1, for exactly one cycle. WA, WD and WEN hold their values until the next write; WEN returns to 0 when WClk_En is 0.
- Throughput: the output register is separate from the shadow, so a byte can be accepted during the write cycle. Sustained rate is 1 byte per cycle.
- In_Last with lane==0 and no byte is not possible: In_Last is only sampled on an accept.
- Full: set in the cycle Word_Cnt becomes 512. When Full is set:
  - In_Ready drops;
  - Done pulses together with Full;
  - state goes to DONE.
- If the 512th word write is caused by In_Last, Done pulses once, not twice.
- Done: pulses the cycle after the final write strobe, or together with Full. Word_Cnt is stable when Done pulses.
- In_Last landing exactly on a 4-byte boundary produces one full-word write (WEN=4'b1111). No empty word is written.
- Pointer never wraps: at DEPTH it is held at 511 and writes are blocked.

Decomposition:
- Shared package `ram_pack_pkg`:
  - constants DEPTH=512, ADDR_W=9, LANES=4;
  - state enum {IDLE, FILL, DONE};
  - function lane_mask(n) -> 4-bit WEN mask.
- One sub-module, `byte_lane_shadow`: shadow register, lane counter, fill mask.
- Top level: FSM, pointer, output register.

Test Plan:
- Start, then bytes 0x11,0x22,0x33,0x44 back-to-back -> cycle after 4th accept: WClk_En=1, WA=0, WD=0x44332211, WEN=4'b1111. Word_Cnt=1 next cycle.
- 6 bytes 0x01..0x06 with In_Last on the 6th -> two writes:
  - WA=0, WD=0x04030201, WEN=4'b1111;
  - WA=1, WD=0x00000605, WEN=4'b0011;
  - Done one cycle after the 2nd strobe; Word_Cnt=2.
- 2048 bytes with In_Valid always high, no In_Last -> 512 strobes at WA 0..511. Then Full=1, Done pulse, In_Ready=0, and further In_Valid is ignored.
- In_Valid toggled randomly on 10 bytes with In_Last -> writes identical to the gap-free case. No strobe without a completed word.
- Start asserted after 2 bytes of a frame -> no write. The next 4 bytes are written at WA=0 with WEN=4'b1111.
- Rst_n pulsed low mid-word, asynchronously between edges -> all outputs 0 immediately. After release, Start plus 4 bytes writes at WA=0.

Source files
------------

// File: rtl/ram_pack_pkg.sv
// Shared constants, FSM state type and byte-enable helper for the
// 512x32 write-side byte packer.
package ram_pack_pkg;

    localparam int ADDR_W = 9;
    localparam int DEPTH  = 512;
    localparam int LANES  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_e;

    // Byte-enable mask for a word holding n filled lanes, starting at lane 0.
    function automatic logic [3:0] lane_mask(input logic [2:0] n);
        logic [3:0] m;
        case (n)
            3'd1:    m = 4'b0001;
            3'd2:    m = 4'b0011;
            3'd3:    m = 4'b0111;
            3'd4:    m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/byte_lane_shadow.sv
// Little-endian shadow word: collects accepted bytes lane by lane and
// presents the merged word, fill mask and word-complete flag combinationally.
module byte_lane_shadow
    import ram_pack_pkg::*;
(
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        clear_i,
    input  logic        accept_i,
    input  logic        last_i,
    input  logic [7:0]  data_i,
    output logic [31:0] word_o,
    output logic [3:0]  mask_o,
    output logic        complete_o
);

    logic [31:0] shadow_q, shadow_d;
    logic [1:0]  lane_q, lane_d;
    logic [31:0] merged_s;
    logic        complete_s;

    // Merge the incoming byte into the current lane of the shadow word.
    always_comb begin
        merged_s = shadow_q;
        case (lane_q)
            2'd0:    merged_s[7:0]   = data_i;
            2'd1:    merged_s[15:8]  = data_i;
            2'd2:    merged_s[23:16] = data_i;
            2'd3:    merged_s[31:24] = data_i;
            default: merged_s        = shadow_q;
        endcase
        complete_s = accept_i && ((lane_q == 2'd3) || last_i);
    end

    // Next shadow/lane: a completed word is handed off and the shadow starts empty.
    always_comb begin
        shadow_d = shadow_q;
        lane_d   = lane_q;
        if (clear_i) begin
            shadow_d = 32'd0;
            lane_d   = 2'd0;
        end else if (complete_s) begin
            shadow_d = 32'd0;
            lane_d   = 2'd0;
        end else if (accept_i) begin
            shadow_d = merged_s;
            lane_d   = lane_q + 2'd1;
        end else begin
            shadow_d = shadow_q;
            lane_d   = lane_q;
        end
    end

    // Shadow and lane registers.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            shadow_q <= 32'd0;
            lane_q   <= 2'd0;
        end else begin
            shadow_q <= shadow_d;
            lane_q   <= lane_d;
        end
    end

    assign word_o     = merged_s;
    assign mask_o     = lane_mask({1'b0, lane_q} + 3'd1);
    assign complete_o = complete_s;

endmodule

// File: rtl/ram512x32_byte_packer.sv
// Byte-stream to 32-bit RAM write-port feeder: frame FSM, write pointer,
// registered RAM write port, word counter and Full/Done flags.
module ram512x32_byte_packer #(
    parameter int ADDR_W = ram_pack_pkg::ADDR_W,
    parameter int DEPTH  = ram_pack_pkg::DEPTH,
    parameter int LANES  = ram_pack_pkg::LANES
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic                 Start,
    input  logic [7:0]           In_Data,
    input  logic                 In_Valid,
    input  logic                 In_Last,
    output logic                 In_Ready,
    output logic [ADDR_W-1:0]    WA,
    output logic [8*LANES-1:0]   WD,
    output logic [LANES-1:0]     WEN,
    output logic                 WClk_En,
    output logic [ADDR_W:0]      Word_Cnt,
    output logic                 Full,
    output logic                 Done
);

    import ram_pack_pkg::*;

    typedef logic [ADDR_W:0] cnt_t;
    localparam cnt_t LAST_WORD = cnt_t'(DEPTH - 1);
    localparam cnt_t FULL_CNT  = cnt_t'(DEPTH);

    state_e              state_q, state_d;
    cnt_t                ptr_q, ptr_d;
    cnt_t                cnt_q, cnt_d;
    logic                full_q, full_d;
    logic [ADDR_W-1:0]   wa_q, wa_d;
    logic [8*LANES-1:0]  wd_q, wd_d;
    logic [LANES-1:0]    wen_q, wen_d;
    logic                wclk_en_q, wclk_en_d;
    logic                close_q, close_d;
    logic                done_q, done_d;

    logic                in_ready_s;
    logic                accept_s;
    logic                complete_s;
    logic                final_word_s;
    logic [31:0]         word_s;
    logic [3:0]          mask_s;

    byte_lane_shadow u_shadow (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .clear_i    (Start),
        .accept_i   (accept_s),
        .last_i     (In_Last),
        .data_i     (In_Data),
        .word_o     (word_s),
        .mask_o     (mask_s),
        .complete_o (complete_s)
    );

    // FSM state register.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; the frame closes when the handed-off word is the last one.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (Start) state_d = FILL;
                else       state_d = IDLE;
            end
            FILL: begin
                if (Start)             state_d = FILL;
                else if (final_word_s) state_d = DONE;
                else                   state_d = FILL;
            end
            DONE: begin
                if (Start) state_d = FILL;
                else       state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: handshake and frame-closing word detection.
    always_comb begin
        in_ready_s   = (state_q == FILL) && !full_q && !Start;
        accept_s     = In_Valid && in_ready_s;
        final_word_s = complete_s && (In_Last || (ptr_q == LAST_WORD));
    end

    // Datapath next state. ptr_q reserves the address when a word completes,
    // so back-to-back completions still get consecutive addresses; Word_Cnt
    // advances in the strobe cycle itself.
    always_comb begin
        wa_d      = wa_q;
        wd_d      = wd_q;
        wen_d     = {LANES{1'b0}};
        wclk_en_d = 1'b0;
        if (complete_s && (ptr_q != FULL_CNT)) begin
            wa_d      = ptr_q[ADDR_W-1:0];
            wd_d      = word_s;
            wen_d     = mask_s;
            wclk_en_d = 1'b1;
        end else begin
            wa_d      = wa_q;
            wd_d      = wd_q;
        end

        if (Start) begin
            ptr_d  = cnt_t'(0);
            cnt_d  = cnt_t'(0);
            full_d = 1'b0;
        end else begin
            if (complete_s && (ptr_q != FULL_CNT)) ptr_d = ptr_q + cnt_t'(1);
            else                                   ptr_d = ptr_q;
            if (wclk_en_q && (cnt_q != FULL_CNT))  cnt_d = cnt_q + cnt_t'(1);
            else                                   cnt_d = cnt_q;
            if (wclk_en_q && (cnt_q == LAST_WORD)) full_d = 1'b1;
            else                                   full_d = full_q;
        end

        close_d = final_word_s;
        done_d  = close_q;
    end

    // Datapath and output registers.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            ptr_q     <= cnt_t'(0);
            cnt_q     <= cnt_t'(0);
            full_q    <= 1'b0;
            wa_q      <= {ADDR_W{1'b0}};
            wd_q      <= {(8*LANES){1'b0}};
            wen_q     <= {LANES{1'b0}};
            wclk_en_q <= 1'b0;
            close_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            full_q    <= full_d;
            wa_q      <= wa_d;
            wd_q      <= wd_d;
            wen_q     <= wen_d;
            wclk_en_q <= wclk_en_d;
            close_q   <= close_d;
            done_q    <= done_d;
        end
    end

    assign In_Ready = in_ready_s;
    assign WA       = wa_q;
    assign WD       = wd_q;
    assign WEN      = wen_q;
    assign WClk_En  = wclk_en_q;
    assign Word_Cnt = cnt_q;
    assign Full     = full_q;
    assign Done     = done_q;

endmodule
